square_gen_nco: RTL and testbench

//  Programmable square-wave source: stimulus end of the paper-count frequency meter.

---
 rtl/square_gen_nco_if.sv | 20 ++
 rtl/square_gen_nco.sv | 119 +++++++++++
 tb/tb_square_gen_nco.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/square_gen_nco_if.sv
// Frequency-word load channel for the square-wave NCO (valid/ready).
interface square_gen_nco_if #(
    parameter int unsigned F_W = 28
);
    logic [F_W-1:0] freq_hz;
    logic           freq_valid;
    logic           freq_ready;

    modport master (
        output freq_hz,
        output freq_valid,
        input  freq_ready
    );

    modport slave (
        input  freq_hz,
        input  freq_valid,
        output freq_ready
    );
endinterface

// File: rtl/square_gen_nco.sv
// Programmable 50%-duty square-wave source. A modulo-CLK_HZ phase accumulator stepping by
// 2*f toggles the output exactly 2*f times per CLK_HZ cycles. New frequency words arriving
// while running are held and applied on the next falling edge of the output.
module square_gen_nco #(
    parameter int unsigned CLK_HZ = 6_000_000,
    parameter int unsigned F_W    = 28,
    parameter int unsigned ACC_W  = 24
) (
    input  logic            clk_6M,
    input  logic            reset,
    input  logic            enable,
    square_gen_nco_if.slave freq_if,
    output logic            square,
    output logic            period_done,
    output logic            clamp_err
);

    localparam logic [F_W-1:0]   F_MAX   = F_W'(CLK_HZ / 2);
    localparam logic [ACC_W-1:0] MODULUS = ACC_W'(CLK_HZ);

    logic             square_q, square_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [F_W-1:0]   active_f_q, active_f_d;
    logic             pend_q, pend_d;
    logic [F_W-1:0]   pend_f_q, pend_f_d;
    logic             period_done_q, period_done_d;
    logic             clamp_err_q, clamp_err_d;

    logic             accept;
    logic             clamped;
    logic [F_W-1:0]   f_c;
    logic             running;
    logic [ACC_W-1:0] step;
    logic [ACC_W-1:0] sum;
    logic             wrap;

    // Handshake, clamp and accumulator datapath.
    always_comb begin
        accept  = freq_if.freq_valid & ~pend_q;
        clamped = freq_if.freq_hz > F_MAX;
        f_c     = clamped ? F_MAX : freq_if.freq_hz;
        running = enable & (active_f_q != '0);
        // active_f never exceeds CLK_HZ/2, so 2*active_f fits in ACC_W bits.
        step    = ACC_W'({active_f_q, 1'b0});
        sum     = acc_q + step;
        wrap    = sum >= MODULUS;
    end

    // Next-state: idle/disabled holds the output low, running advances the phase.
    always_comb begin
        square_d      = square_q;
        acc_d         = acc_q;
        active_f_d    = active_f_q;
        pend_d        = pend_q;
        pend_f_d      = pend_f_q;
        period_done_d = 1'b0;
        clamp_err_d   = accept & clamped;

        if (!running) begin
            square_d = 1'b0;
            acc_d    = '0;
            // Disabling flushes a waiting word straight into active_f.
            if (!enable && pend_q) begin
                active_f_d = pend_f_q;
                pend_d     = 1'b0;
            end
            if (accept) begin
                active_f_d = f_c;
            end
        end else begin
            if (wrap) begin
                acc_d    = sum - MODULUS;
                square_d = ~square_q;
                if (square_q) begin
                    period_done_d = 1'b1;
                    // Whole-period boundary: switch to the waiting word from phase zero.
                    if (pend_q) begin
                        active_f_d = pend_f_q;
                        acc_d      = '0;
                        pend_d     = 1'b0;
                    end
                end
            end else begin
                acc_d = sum;
            end
            if (accept) begin
                pend_d   = 1'b1;
                pend_f_d = f_c;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_6M) begin
        if (reset) begin
            square_q      <= 1'b0;
            acc_q         <= '0;
            active_f_q    <= '0;
            pend_q        <= 1'b0;
            pend_f_q      <= '0;
            period_done_q <= 1'b0;
            clamp_err_q   <= 1'b0;
        end else begin
            square_q      <= square_d;
            acc_q         <= acc_d;
            active_f_q    <= active_f_d;
            pend_q        <= pend_d;
            pend_f_q      <= pend_f_d;
            period_done_q <= period_done_d;
            clamp_err_q   <= clamp_err_d;
        end
    end

    assign freq_if.freq_ready = ~pend_q;
    assign square             = square_q;
    assign period_done        = period_done_q;
    assign clamp_err          = clamp_err_q;

endmodule

// File: tb/tb_square_gen_nco.sv
// Scoreboard bench for square_gen_nco. The reference model tracks cycles since the last
// phase restart and derives the output in closed form: toggles = floor(2*f*k / CLK_HZ).
module tb_square_gen_nco;

    localparam int unsigned CLK_HZ = 6_000_000;
    localparam int unsigned F_W    = 28;
    localparam int unsigned ACC_W  = 24;
    localparam longint unsigned HALF = CLK_HZ / 2;

    logic clk_6M = 1'b0;
    always #5 clk_6M = ~clk_6M;

    logic reset;
    logic enable;
    logic square;
    logic period_done;
    logic clamp_err;

    square_gen_nco_if #(.F_W(F_W)) freq_if ();

    square_gen_nco #(
        .CLK_HZ(CLK_HZ),
        .F_W   (F_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk_6M     (clk_6M),
        .reset      (reset),
        .enable     (enable),
        .freq_if    (freq_if),
        .square     (square),
        .period_done(period_done),
        .clamp_err  (clamp_err)
    );

    typedef struct packed {
        logic sq;
        logic pd;
        logic ce;
        logic rdy;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model state.
    longint unsigned m_f      = 0;
    longint unsigned m_k      = 0;
    longint unsigned m_pend_f = 0;
    bit              m_pend   = 0;
    bit              m_sq     = 0;
    bit              m_acc    = 0;

    // Rise counter over a measurement window.
    bit count_en = 0;
    bit prev_sq  = 0;
    int rises    = 0;

    task automatic model_edge();
        bit              pd;
        bit              ce;
        bit              nsq;
        longint unsigned req;
        longint unsigned fc;
        obs_t            e;
        pd = 0;
        ce = 0;
        if (reset) begin
            m_f    = 0;
            m_k    = 0;
            m_pend = 0;
            m_sq   = 0;
            m_acc  = 0;
        end else begin
            req   = longint'(freq_if.freq_hz);
            m_acc = freq_if.freq_valid && !m_pend;
            fc    = (req > HALF) ? HALF : req;
            ce    = m_acc && (req > HALF);
            if (!enable || m_f == 0) begin
                m_sq = 0;
                m_k  = 0;
                if (!enable && m_pend) begin
                    m_f    = m_pend_f;
                    m_pend = 0;
                end
                if (m_acc) m_f = fc;
            end else begin
                m_k  = m_k + 1;
                nsq  = (((2 * m_f * m_k) / CLK_HZ) % 2) == 1;
                pd   = m_sq && !nsq;
                m_sq = nsq;
                if (pd && m_pend) begin
                    m_f    = m_pend_f;
                    m_k    = 0;
                    m_pend = 0;
                end else if (m_acc) begin
                    m_pend   = 1;
                    m_pend_f = fc;
                end
            end
        end
        e.sq  = m_sq;
        e.pd  = pd;
        e.ce  = ce;
        e.rdy = !m_pend;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_6M);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic offer(input longint unsigned f);
        int n;
        freq_if.freq_hz    = F_W'(f);
        freq_if.freq_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 400);
        freq_if.freq_valid = 1'b0;
        if (!m_acc) begin
            checks++;
            errors++;
            $display("FAIL handshake for %0d: not accepted within 400 cycles", f);
        end
    endtask

    // Monitor: compare every presented cycle against the scoreboard.
    always @(negedge clk_6M) begin
        obs_t e;
        obs_t got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = '{square, period_done, clamp_err, freq_if.freq_ready};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL outputs near cycle %0d: sq/pd/ce/rdy got %b required %b",
                         cyc, got, e);
            end
        end
        if (count_en && square && !prev_sq) rises++;
        prev_sq = square;
    end

    initial begin
        longint unsigned f;
        int              exp_rises;
        reset              = 1'b1;
        enable             = 1'b1;
        freq_if.freq_valid = 1'b0;
        freq_if.freq_hz    = '0;

        // Reset, then idle with no word loaded.
        run(5);
        reset = 1'b0;
        run(100);

        // 1.5 MHz from idle: period 4.
        offer(1_500_000);
        run(40);

        // Switch to 100 kHz while running: waits for a falling edge.
        offer(100_000);
        run(200);

        // Over-range request is clamped to CLK_HZ/2.
        offer(5_000_000);
        run(100);

        // 440 kHz: exact rise count over a window.
        enable = 1'b0;
        tick();
        offer(440_000);
        enable   = 1'b1;
        rises    = 0;
        count_en = 1;
        run(75_000);
        @(negedge clk_6M);
        #1;
        count_en  = 0;
        exp_rises = int'((64'd440_000 * 64'd75_000) / CLK_HZ);
        checks++;
        if (rises != exp_rises) begin
            errors++;
            $display("FAIL rise_count: got %0d required %0d", rises, exp_rises);
        end

        // Pending word dropped by reset.
        offer(100_000);
        run(20);
        offer(1_500_000);
        run(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run(10);

        // Pending word applied by disable.
        offer(100_000);
        run(20);
        offer(200_000);
        run(3);
        enable = 1'b0;
        run(5);
        enable = 1'b1;
        run(100);

        // Randomized traffic.
        for (int it = 0; it < 20; it++) begin
            case ($urandom_range(0, 7))
                0:       f = 0;
                1:       f = longint'($urandom_range(3_000_001, 9_000_000));
                default: f = longint'($urandom_range(1_000, 3_000_000));
            endcase
            enable = ($urandom_range(0, 4) != 0);
            offer(f);
            run(int'($urandom_range(20, 300)));
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
        end

        enable = 1'b1;
        run(3);
        @(negedge clk_6M);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
